// File: rtl/ram_dp_pkg.sv
// Shared defaults and state type for the dual-port RAM controller.
package ram_dp_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DEPTH_DEF      = 4096;

    // INIT: zero-fill sweep in progress; READY: user requests accepted.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/ram_dp_init_fsm.sv
// Init/ready state machine for ram_dp_ctrl. Holds the state register and
// the clear counter that walks every address once after reset, driving
// the clear address and clear write enable for the zero-fill sweep.
module ram_dp_init_fsm
    import ram_dp_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    output state_t                o_state,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output logic                  o_clr_we
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_next_cnt;

    // State and clear-counter registers; reset restarts the sweep at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_clr_cnt <= w_next_cnt;
        end
    end

    // Next state: one address per cycle in INIT, leave after the last one.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_clr_cnt;
        case (r_state)
            INIT: begin
                if (r_clr_cnt == LAST_ADDR) begin
                    w_next_state = READY;
                end else begin
                    w_next_cnt = r_clr_cnt + 1'b1;
                end
            end
            READY: begin
                w_next_state = READY;
            end
            default: begin
                w_next_state = INIT;
            end
        endcase
    end

    assign o_state    = r_state;
    assign o_clr_addr = r_clr_cnt;
    // No clear write on a reset cycle; the sweep starts on the next edge.
    assign o_clr_we   = (r_state == INIT) && !rst;

endmodule

// File: rtl/ram_dp_ctrl.sv
// Dual-port (1 write, 1 read) RAM controller with a zero-fill sweep after
// reset, registered reads of latency 1 and write-first bypass.
// Optional macro RAM_PARITY_EN adds an even-parity bit per word and the
// parity_err output.
module ram_dp_ctrl
    import ram_dp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_enb,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enb,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  ready
`ifdef RAM_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    state_t                w_state;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_clr_we;
    logic                  w_ready;
    logic                  w_usr_we;
    logic                  w_rd_fire;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic                  w_bypass;
    logic [DATA_WIDTH-1:0] w_rd_data;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;

    ram_dp_init_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_init_fsm (
        .clk        (clk),
        .rst        (rst),
        .o_state    (w_state),
        .o_clr_addr (w_clr_addr),
        .o_clr_we   (w_clr_we)
    );

    // User requests only count once the sweep is done and reset is low.
    assign w_ready    = (w_state == READY);
    assign w_usr_we   = w_ready && wr_enb && !rst;
    assign w_rd_fire  = w_ready && rd_enb && !rst;

    // The sweep owns the write port while it runs.
    assign w_mem_we   = w_clr_we || w_usr_we;
    assign w_mem_addr = w_clr_we ? w_clr_addr : wr_address;
    assign w_mem_data = w_clr_we ? '0 : data_in;

    // Write-first: a same-address write in the read cycle wins.
    assign w_bypass   = w_usr_we && (wr_address == rd_address);
    assign w_rd_data  = w_bypass ? data_in : r_mem[rd_address];

    // Storage array; contents are defined by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Read-data register: new result on rd_valid, otherwise hold data_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_rd_fire) begin
            r_data_out <= w_rd_data;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
    assign ready    = w_ready;

`ifdef RAM_PARITY_EN
    logic       r_par [DEPTH];
    logic       w_mem_par;
    logic       w_rd_par;
    logic       r_parity_err;

    assign w_mem_par = w_clr_we ? 1'b0 : ^data_in;
    assign w_rd_par  = w_bypass ? ^data_in : r_par[rd_address];

    // Parity bit stored alongside each word.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_par[w_mem_addr] <= w_mem_par;
        end
    end

    // Parity check registered with the read so it lines up with rd_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (w_rd_fire) begin
            r_parity_err <= (^w_rd_data) != w_rd_par;
        end else begin
            r_parity_err <= 1'b0;
        end
    end

    assign parity_err = r_parity_err;
`endif

endmodule
